// File: rtl/wb_line_buffer_ctrl_if.sv
// rtl/wb_line_buffer_ctrl_if.sv - Wishbone slave, line buffer port A and DDR engine request signals
// slave modport is taken by the controller; master modport is the bus/buffer/engine side.
interface wb_line_buffer_ctrl_if #(
   parameter int ADDR_WIDTH = 3
);
   logic [31:0]            wb_adr_i;
   logic [31:0]            wb_dat_i;
   logic [3:0]             wb_sel_i;
   logic                   wb_we_i;
   logic                   wb_cyc_i;
   logic                   wb_stb_i;
   logic [2:0]             wb_cti_i;
   logic [1:0]             wb_bte_i;
   logic [31:0]            wb_dat_o;
   logic                   wb_ack_o;

   logic [ADDR_WIDTH-1:0]  buf_addr_o;
   logic [3:0]             buf_we_o;
   logic [31:0]            buf_di_o;
   logic [31:0]            buf_do_i;

   logic                   ddr_req_o;
   logic                   ddr_we_o;
   logic [29-ADDR_WIDTH:0] ddr_adr_o;
   logic                   ddr_ack_i;

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
      output wb_dat_o, wb_ack_o,
      output buf_addr_o, buf_we_o, buf_di_o,
      input  buf_do_i,
      output ddr_req_o, ddr_we_o, ddr_adr_o,
      input  ddr_ack_i
   );

   modport master (
      output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
      input  wb_dat_o, wb_ack_o,
      input  buf_addr_o, buf_we_o, buf_di_o,
      output buf_do_i,
      input  ddr_req_o, ddr_we_o, ddr_adr_o,
      output ddr_ack_i
   );
endinterface

// File: rtl/wb_line_buffer_ctrl.sv
// rtl/wb_line_buffer_ctrl.sv - single-line Wishbone front-end for the DDR line buffer port A
// Optional incrementing-burst support is enabled by defining WB_LINE_BUFFER_BURST_EN.
module wb_line_buffer_ctrl #(
   parameter int ADDR_WIDTH = 3
) (
   input logic                   wb_clk_i,
   input logic                   wb_rst_i,
   wb_line_buffer_ctrl_if.slave  bus
);
   localparam int TW = 30 - ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_OFF = '1;

   typedef enum logic [1:0] {IDLE, ACK, WRBACK, FILL} state_t;

   state_t                state;
   logic                  valid;
   logic                  dirty;
   logic [TW-1:0]         tag_reg;
   logic [TW-1:0]         fill_tag;
   logic [TW-1:0]         ddr_adr_q;
   logic                  ddr_req_q;
   logic                  ddr_we_q;

   logic [ADDR_WIDTH-1:0] off;
   logic [TW-1:0]         tag_in;
   logic                  req;
   logic                  hit;
   logic                  burst_cont;
   logic                  unused_bits;

   assign off    = bus.wb_adr_i[ADDR_WIDTH+1:2];
   assign tag_in = bus.wb_adr_i[31:ADDR_WIDTH+2];
   assign req    = bus.wb_cyc_i & bus.wb_stb_i;
   assign hit    = valid && (tag_reg == tag_in);

`ifdef WB_LINE_BUFFER_BURST_EN
   assign burst_cont  = (bus.wb_cti_i == 3'b010) && (bus.wb_bte_i == 2'b00) && (off != LAST_OFF);
   assign unused_bits = ^bus.wb_adr_i[1:0];
`else
   assign burst_cont  = 1'b0;
   assign unused_bits = ^{bus.wb_adr_i[1:0], bus.wb_cti_i, bus.wb_bte_i, LAST_OFF};
`endif

   // Burst reads look one word ahead so the next beat's data is ready on the following cycle.
   always_comb begin
      bus.buf_addr_o = off;
      bus.buf_we_o   = 4'b0000;
      if (state == ACK && req) begin
         if (bus.wb_we_i)
            bus.buf_we_o = bus.wb_sel_i;
         else if (burst_cont)
            bus.buf_addr_o = off + 1'b1;
      end
   end

   assign bus.wb_ack_o  = (state == ACK) && req;
   assign bus.wb_dat_o  = bus.buf_do_i;
   assign bus.buf_di_o  = bus.wb_dat_i;
   assign bus.ddr_req_o = ddr_req_q;
   assign bus.ddr_we_o  = ddr_we_q;
   assign bus.ddr_adr_o = ddr_adr_q;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state     <= IDLE;
         valid     <= 1'b0;
         dirty     <= 1'b0;
         tag_reg   <= '0;
         fill_tag  <= '0;
         ddr_adr_q <= '0;
         ddr_req_q <= 1'b0;
         ddr_we_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  if (hit) begin
                     state <= ACK;
                  end else begin
                     fill_tag  <= tag_in;
                     ddr_req_q <= 1'b1;
                     if (valid && dirty) begin
                        state     <= WRBACK;
                        ddr_we_q  <= 1'b1;
                        ddr_adr_q <= tag_reg;
                     end else begin
                        state     <= FILL;
                        ddr_we_q  <= 1'b0;
                        ddr_adr_q <= tag_in;
                     end
                  end
               end
            end
            ACK: begin
               if (!req) begin
                  state <= IDLE;
               end else begin
                  if (bus.wb_we_i && (bus.wb_sel_i != 4'b0000))
                     dirty <= 1'b1;
                  if (!burst_cont)
                     state <= IDLE;
               end
            end
            WRBACK: begin
               if (bus.ddr_ack_i) begin
                  state     <= FILL;
                  ddr_we_q  <= 1'b0;
                  ddr_adr_q <= fill_tag;
               end
            end
            FILL: begin
               // The DDR transfer always completes, even if the master has abandoned its cycle.
               if (bus.ddr_ack_i) begin
                  state     <= IDLE;
                  ddr_req_q <= 1'b0;
                  tag_reg   <= fill_tag;
                  valid     <= 1'b1;
                  dirty     <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_wb_line_buffer_ctrl.sv
// tb/tb_wb_line_buffer_ctrl.sv - directed bench for wb_line_buffer_ctrl with a line buffer and DDR model
module tb_wb_line_buffer_ctrl;
   localparam int AW = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb_line_buffer_ctrl_if #(.ADDR_WIDTH(AW)) bus();

   wb_line_buffer_ctrl #(.ADDR_WIDTH(AW)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .bus      (bus)
   );

   int total = 0;
   int bad   = 0;
   logic [31:0] mem [0:7];

   function automatic logic [31:0] pat(input int tag, input int idx);
      return 32'hA000_0000 | (32'(tag) << 8) | 32'(idx);
   endfunction

   // Line buffer: port A per the controller, port B refills the whole line on a DDR refill ack.
   always @(posedge clk) begin
      if (bus.ddr_ack_i && bus.ddr_req_o && !bus.ddr_we_o) begin
         for (int i = 0; i < 8; i++) mem[i] <= pat(int'(bus.ddr_adr_o), i);
      end else begin
         for (int b = 0; b < 4; b++)
            if (bus.buf_we_o[b]) mem[bus.buf_addr_o][8*b +: 8] <= bus.buf_di_o[8*b +: 8];
      end
      bus.buf_do_i <= mem[bus.buf_addr_o];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #2;
   endtask

   task automatic wb_start(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [2:0] cti);
      bus.wb_adr_i = adr;
      bus.wb_we_i  = we;
      bus.wb_dat_i = dat;
      bus.wb_sel_i = sel;
      bus.wb_cti_i = cti;
      bus.wb_bte_i = 2'b00;
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
   endtask

   task automatic wb_stop;
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i  = 1'b0;
      bus.wb_sel_i = 4'b0000;
      bus.wb_cti_i = 3'b000;
   endtask

   task automatic ddr_pulse;
      bus.ddr_ack_i = 1'b1;
      step;
      bus.ddr_ack_i = 1'b0;
      #1;
   endtask

   initial begin
      int          acks [4];
      logic [31:0] bd [4];
      int          beat;
      bit          pend;
      int          exp_c;

      bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_bte_i = 2'b00;
      wb_stop;
      bus.ddr_ack_i = 1'b0;
      rst = 1'b1;
      step; step;
      rst = 1'b0;
      #1;
      check("rst_ack", 32'(bus.wb_ack_o), 32'd0);
      check("rst_req", 32'(bus.ddr_req_o), 32'd0);
      check("rst_buf_we", 32'(bus.buf_we_o), 32'd0);

      ddr_pulse;
      check("idle_ddr_ack_ignored", 32'(bus.ddr_req_o), 32'd0);

      // Cold miss on 0x10, DDR ack in the first request cycle.
      wb_start(32'h10, 1'b0, 32'h0, 4'h0, 3'b000);
      step;
      check("miss_req", 32'(bus.ddr_req_o), 32'd1);
      check("miss_we", 32'(bus.ddr_we_o), 32'd0);
      check("miss_adr", 32'(bus.ddr_adr_o), 32'd0);
      ddr_pulse;
      check("fill_req_drop", 32'(bus.ddr_req_o), 32'd0);
      check("fill_idle_no_ack", 32'(bus.wb_ack_o), 32'd0);
      step;
      check("fill_ack", 32'(bus.wb_ack_o), 32'd1);
      check("fill_data", bus.wb_dat_o, pat(0, 4));
      step;
      wb_stop; #1;
      check("fill_ack_low", 32'(bus.wb_ack_o), 32'd0);

      // Classic hit reads with stb held: ack cycle 1, gap cycle 2, next ack cycle 3.
      wb_start(32'h14, 1'b0, 32'h0, 4'h0, 3'b000);
      step;
      check("hit_ack", 32'(bus.wb_ack_o), 32'd1);
      check("hit_data", bus.wb_dat_o, pat(0, 5));
      step;
      bus.wb_adr_i = 32'h18; #1;
      check("b2b_gap", 32'(bus.wb_ack_o), 32'd0);
      step;
      check("b2b_ack", 32'(bus.wb_ack_o), 32'd1);
      check("b2b_data", bus.wb_dat_o, pat(0, 6));
      step;
      wb_stop;

      // Partial write then read back.
      wb_start(32'h10, 1'b1, 32'hDEAD_BEEF, 4'b0011, 3'b000);
      step;
      check("wr_ack", 32'(bus.wb_ack_o), 32'd1);
      check("wr_buf_we", 32'(bus.buf_we_o), 32'h3);
      step;
      wb_stop; #1;
      check("wr_buf_we_low", 32'(bus.buf_we_o), 32'd0);
      wb_start(32'h10, 1'b0, 32'h0, 4'h0, 3'b000);
      step;
      check("rd_back", bus.wb_dat_o, 32'hA000_BEEF);
      step;
      wb_stop;

      // Dirty line 0, access line 1: writeback then refill.
      wb_start(32'h20, 1'b0, 32'h0, 4'h0, 3'b000);
      step;
      check("wb_req", 32'(bus.ddr_req_o), 32'd1);
      check("wb_we", 32'(bus.ddr_we_o), 32'd1);
      check("wb_adr", 32'(bus.ddr_adr_o), 32'd0);
      ddr_pulse;
      check("wb_fill_req", 32'(bus.ddr_req_o), 32'd1);
      check("wb_fill_we", 32'(bus.ddr_we_o), 32'd0);
      check("wb_fill_adr", 32'(bus.ddr_adr_o), 32'd1);
      ddr_pulse;
      check("wb_req_drop", 32'(bus.ddr_req_o), 32'd0);
      check("wb_idle_no_ack", 32'(bus.wb_ack_o), 32'd0);
      step;
      check("wb_ack", 32'(bus.wb_ack_o), 32'd1);
      check("wb_data", bus.wb_dat_o, pat(1, 0));
      step;
      wb_stop;

      // 4-beat incrementing read; the master advances only after the edge that takes an ack.
      for (int i = 0; i < 4; i++) begin acks[i] = -1; bd[i] = '0; end
      beat = 0;
      pend = 1'b0;
      wb_start(32'h20, 1'b0, 32'h0, 4'h0, 3'b010);
      for (int c = 1; c <= 12 && beat < 4; c++) begin
         @(posedge clk); #1;
         if (pend) begin
            bus.wb_adr_i = 32'h20 + 32'(4 * beat);
            bus.wb_cti_i = (beat == 3) ? 3'b111 : 3'b010;
            pend = 1'b0;
         end
         #1;
         if (bus.wb_ack_o) begin
            acks[beat] = c;
            bd[beat]   = bus.wb_dat_o;
            beat++;
            pend = 1'b1;
         end
      end
      step;
      wb_stop; #1;
      check("burst_end_ack", 32'(bus.wb_ack_o), 32'd0);
      for (int i = 0; i < 4; i++) begin
`ifdef WB_LINE_BUFFER_BURST_EN
         exp_c = i + 1;
`else
         exp_c = 2 * i + 1;
`endif
         check($sformatf("burst_cyc%0d", i), 32'(acks[i]), 32'(exp_c));
         check($sformatf("burst_dat%0d", i), bd[i], pat(1, i));
      end

      // Burst request at the last offset gets a single ack.
      wb_start(32'h3C, 1'b0, 32'h0, 4'h0, 3'b010);
      step;
      check("edge_ack", 32'(bus.wb_ack_o), 32'd1);
      check("edge_data", bus.wb_dat_o, pat(1, 7));
      step;
      check("edge_no_second_ack", 32'(bus.wb_ack_o), 32'd0);
      wb_stop;

      // Write burst abandoned after one beat: no further ack, no write.
      wb_start(32'h20, 1'b1, 32'h1234_5678, 4'hF, 3'b010);
      step;
      check("drop_ack", 32'(bus.wb_ack_o), 32'd1);
      step;
      bus.wb_adr_i = 32'h24;
      bus.wb_cyc_i = 1'b0; #1;
      check("drop_no_ack", 32'(bus.wb_ack_o), 32'd0);
      check("drop_no_we", 32'(bus.buf_we_o), 32'd0);
      wb_stop;
      wb_start(32'h24, 1'b0, 32'h0, 4'h0, 3'b000);
      step;
      check("drop_rd1", bus.wb_dat_o, pat(1, 1));
      step;
      wb_stop;
      wb_start(32'h20, 1'b0, 32'h0, 4'h0, 3'b000);
      step;
      check("drop_rd0", bus.wb_dat_o, 32'h1234_5678);
      step;
      wb_stop;

      // Reset in the middle of FILL.
      wb_start(32'h40, 1'b0, 32'h0, 4'h0, 3'b000);
      step;
      check("rf_wb_we", 32'(bus.ddr_we_o), 32'd1);
      check("rf_wb_adr", 32'(bus.ddr_adr_o), 32'd1);
      ddr_pulse;
      check("rf_fill_adr", 32'(bus.ddr_adr_o), 32'd2);
      rst = 1'b1;
      wb_stop;
      step;
      check("rf_req_cleared", 32'(bus.ddr_req_o), 32'd0);
      rst = 1'b0;
      wb_start(32'h20, 1'b0, 32'h0, 4'h0, 3'b000);
      step;
      check("rf_post_miss_req", 32'(bus.ddr_req_o), 32'd1);
      check("rf_post_miss_we", 32'(bus.ddr_we_o), 32'd0);
      check("rf_post_miss_adr", 32'(bus.ddr_adr_o), 32'd1);
      ddr_pulse;
      step;
      check("rf_post_ack", 32'(bus.wb_ack_o), 32'd1);
      check("rf_post_data", bus.wb_dat_o, pat(1, 0));
      step;
      wb_stop;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
